fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
// - Fetch sequencer: owns the architectural PC register, drives the instruction-memory
//   request/ack handshake and applies next-PC redirects (branch/jump/jr) from decode.
// - Sits between IMEM and the decode stage; replaces the free-running PC+4 register.
// - Presents one fetched instruction at a time to decode via a valid/ready buffer.
// PARAMETERS
// - RESET_PC   32'h0000_3000   PC value loaded on reset; first fetch address
// - OP_W       2               width of npc_op; encoding PLUS4=0, BRANCH=1, JUMP=2, RS=3
// PORTS
// - clk         in   1    clock, all state on rising edge
// - rstn        in   1    asynchronous, active-low reset
// - imem_req    out  1    fetch request; held until imem_ack
// - imem_addr   out  32   fetch address (= PC register); [1:0] always 2'b00
// - imem_ack    in   1    request accepted; imem_rdata valid this cycle
// - imem_rdata  in   32   fetched instruction word
// - inst_valid  out  1    inst_out/inst_pc hold a live instruction
// - inst_ready  in   1    decode consumes the instruction when inst_valid & inst_ready
// - inst_out    out  32   buffered instruction
// - inst_pc     out  32   address of inst_out
// - redir_valid in   1    redirect request from decode (1-cycle pulse)
// - redir_op    in   OP_W next-PC operation for the redirect
// - redir_pc    in   32   PC of the redirecting instruction
// - redir_imm   in   26   immediate (imm16 in [15:0] for BRANCH, index26 for JUMP)
// - redir_rs    in   32   register target for RS
// - fetch_err   out  1    1-cycle pulse: RS target had nonzero [1:0] (truncated)
// BEHAVIOUR
// - Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req=0,
//   inst_valid=0, inst_out=0, inst_pc=0, fetch_err=0, pending target=0.
// - Target (p4 = redir_pc+4): PLUS4 -> p4; BRANCH -> p4 + sext(imm[15:0])<<2;
//   JUMP -> {p4[31:28],imm,2'b00}; RS -> {rs[31:2],2'b00}. All 32-bit, wrap mod 2^32.
// - FSM states: IDLE, REQ, HOLD, DRAIN. imem_req=1 in REQ and DRAIN only.
//   IDLE : -> REQ unconditionally (first request one cycle after reset release).
//   REQ  : ack & !redir -> latch rdata/pc into buffer, inst_valid=1, -> HOLD.
//          ack & redir  -> discard rdata, pc=target, stay REQ (new addr next cycle).
//          !ack & redir -> pend=target, -> DRAIN (imem_addr held stable).
//          else stay REQ, addr stable.
//   HOLD : redir -> inst_valid=0, pc=target, -> REQ (redir beats inst_ready).
//          inst_ready -> inst_valid=0, pc=pc+4, -> REQ.
//   DRAIN: redir -> pend=latest target (last wins). ack -> discard rdata, pc=pend
//          (or new target if redir same cycle), -> REQ.
// - Max one outstanding request; imem_addr/imem_req never change while awaiting ack.
// - Throughput: zero-wait IMEM + inst_ready tied 1 -> one instruction every 2 cycles.
// - inst_valid never asserted for a squashed fetch; PC+4 wraps 0xFFFF_FFFC -> 0.
// - fetch_err pulses in the cycle after an RS redirect with redir_rs[1:0]!=0.
// - rstn assert mid-handshake: everything returns to reset values immediately;
//   outstanding IMEM request is abandoned (IMEM must also be reset).
// STRUCTURE
// - Shared package/header: NPC op codes (PLUS4/BRANCH/JUMP/RS), FSM state encoding,
//   RESET_PC default.
// - One sub-module: npc_calc (combinational target computation above); FSM, PC,
//   pending-target and output buffer registers stay in fetch_seq.
// TESTING
// - Reset, imem_ack tied 1, inst_ready=1 -> addrs 0x3000,0x3004,0x3008 at 2-cycle
//   spacing; inst_pc matches; no fetch_err.
// - inst_ready=0 for 5 cycles in HOLD -> inst_valid/inst_out stable, imem_req=0, no
//   new addr; release -> next addr pc+4.
// - BRANCH redir_pc=0x3010 imm=0xFFFC while in HOLD -> buffer flushed, next
//   imem_addr=0x3004.
// - imem_ack delayed 3 cycles, JUMP imm=0x0000100 during wait -> DRAIN, old addr held,
//   rdata discarded, next addr 0x0000_0400, no inst_valid for squashed word.
// - Two redirects in DRAIN (JUMP then RS rs=0x0000_5002) -> next addr 0x5000,
//   fetch_err pulses once.
// - rstn low mid-DRAIN -> all outputs reset values same cycle; restart at 0x3000.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared constants for the fetch sequencer.
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - NPC_* codes      : next-PC operation encoding carried on redir_op
//   - ST_* codes       : fetch FSM state encoding
//   - pc_plus4()       : sequential next-PC helper (wraps mod 2^32)
package fetch_seq_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          NPC_OP_W         = 2;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory request/ack bus.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word-aligned fetch address
//   imem_ack   : request accepted, imem_rdata valid this cycle
//   imem_rdata : fetched instruction word
// master = fetch sequencer side, slave = instruction memory side.
interface fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_seq_npc_calc.sv
// fetch_seq_npc_calc: combinational redirect-target computation.
//   op       : next-PC operation (PLUS4/BRANCH/JUMP/RS)
//   pc       : PC of the redirecting instruction
//   imm      : imm16 in [15:0] for BRANCH, index26 for JUMP
//   rs       : register target for RS
//   target   : word-aligned next PC
//   misalign : RS target had nonzero [1:0] and was truncated
module fetch_seq_npc_calc
  import fetch_seq_pkg::*;
#(
  parameter int OP_W = NPC_OP_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     pc,
  input  logic [25:0]     imm,
  input  logic [31:0]     rs,
  output logic [31:0]     target,
  output logic            misalign
);

  logic [31:0] p4_s;
  logic [31:0] br_off_s;

  // Select the next-PC target; all arithmetic wraps mod 2^32.
  always_comb begin
    p4_s     = pc_plus4(pc);
    br_off_s = {{14{imm[15]}}, imm[15:0], 2'b00};
    misalign = 1'b0;
    case (op)
      NPC_PLUS4:  target = p4_s;
      NPC_BRANCH: target = p4_s + br_off_s;
      NPC_JUMP:   target = {p4_s[31:28], imm, 2'b00};
      NPC_RS: begin
        target   = {rs[31:2], 2'b00};
        misalign = (rs[1:0] != 2'b00);
      end
      default:    target = p4_s;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: fetch sequencer owning the architectural PC.
//   clk, rstn   : clock, asynchronous active-low reset
//   imem        : instruction-memory request/ack bus (master side)
//   inst_valid/inst_ready/inst_out/inst_pc : one-entry buffer towards decode
//   redir_*     : next-PC redirect from decode (1-cycle pulse)
//   fetch_err   : pulse in the cycle after an RS redirect with a misaligned target
// At most one IMEM request is outstanding; a redirect that arrives while a request
// is unacknowledged is parked in pend_r (DRAIN) so the bus stays stable until ack.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          OP_W     = NPC_OP_W
) (
  input  logic            clk,
  input  logic            rstn,
  fetch_seq_if.master     imem,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_out,
  output logic [31:0]     inst_pc,
  input  logic            redir_valid,
  input  logic [OP_W-1:0] redir_op,
  input  logic [31:0]     redir_pc,
  input  logic [25:0]     redir_imm,
  input  logic [31:0]     redir_rs,
  output logic            fetch_err
);

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] pend_r;
  logic        req_r;
  logic        valid_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic        err_r;

  logic [1:0]  state_nxt_s;
  logic [31:0] pc_nxt_s;
  logic [31:0] pend_nxt_s;
  logic        load_buf_s;
  logic        drop_buf_s;
  logic [31:0] target_s;
  logic        misalign_s;

  fetch_seq_npc_calc #(.OP_W(OP_W)) u_npc_calc (
    .op       (redir_op),
    .pc       (redir_pc),
    .imm      (redir_imm),
    .rs       (redir_rs),
    .target   (target_s),
    .misalign (misalign_s)
  );

  // Next-state, next-PC and buffer-control decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    pend_nxt_s  = pend_r;
    load_buf_s  = 1'b0;
    drop_buf_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem.imem_ack && !redir_valid) begin
          load_buf_s  = 1'b1;
          state_nxt_s = ST_HOLD;
        end else if (imem.imem_ack) begin
          // Word arrived but is already stale: drop it and fetch the target.
          pc_nxt_s = target_s;
        end else if (redir_valid) begin
          // Address must stay stable until ack, so park the target.
          pend_nxt_s  = target_s;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        // A redirect outranks consumption of the buffered word.
        if (redir_valid) begin
          drop_buf_s  = 1'b1;
          pc_nxt_s    = target_s;
          state_nxt_s = ST_REQ;
        end else if (inst_ready) begin
          drop_buf_s  = 1'b1;
          pc_nxt_s    = pc_plus4(pc_r);
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (redir_valid) begin
          pend_nxt_s = target_s;
        end else begin
          pend_nxt_s = pend_r;
        end
        if (imem.imem_ack) begin
          pc_nxt_s    = redir_valid ? target_s : pend_r;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM, PC, pending target and request registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      pend_r  <= 32'd0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      pend_r  <= pend_nxt_s;
      req_r   <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DRAIN);
    end
  end

  // Decode-facing instruction buffer and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r   <= 1'b0;
      inst_r    <= 32'd0;
      inst_pc_r <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      if (load_buf_s) begin
        valid_r   <= 1'b1;
        inst_r    <= imem.imem_rdata;
        inst_pc_r <= pc_r;
      end else if (drop_buf_s) begin
        valid_r   <= 1'b0;
      end else begin
        valid_r   <= valid_r;
      end
      err_r <= redir_valid && misalign_s;
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign inst_valid     = valid_r;
  assign inst_out       = inst_r;
  assign inst_pc        = inst_pc_r;
  assign fetch_err      = err_r;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed scenario tasks plus a randomized run checked against
// a transaction-level model of the fetch/redirect rules.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ack = 1'b0;
  logic        ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_op = 2'd0;
  logic [31:0] redir_pc = 32'd0;
  logic [25:0] redir_imm = 26'd0;
  logic [31:0] redir_rs = 32'd0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  fetch_seq_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] op, input logic [31:0] pc,
                                             input logic [25:0] imm, input logic [31:0] rs);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = pc + 32'd4;
    off = {{16{imm[15]}}, imm[15:0]};
    case (op)
      2'd0:    return p4;
      2'd1:    return p4 + off * 32'd4;
      2'd2:    return (p4 & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
      default: return rs & 32'hFFFF_FFFC;
    endcase
  endfunction

  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  fetch_seq dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem        (bus.master),
    .inst_valid  (inst_valid),
    .inst_ready  (ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .redir_valid (redir_valid),
    .redir_op    (redir_op),
    .redir_pc    (redir_pc),
    .redir_imm   (redir_imm),
    .redir_rs    (redir_rs),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic drive_redir(input logic [1:0] op, input logic [31:0] pc,
                             input logic [25:0] imm, input logic [31:0] rs);
    redir_valid = 1'b1;
    redir_op    = op;
    redir_pc    = pc;
    redir_imm   = imm;
    redir_rs    = rs;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ack = 1'b0; ready = 1'b0; redir_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0000_3000) begin failures++; $display("FAIL reset_addr got=%h exp=00003000", bus.imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_out !== 32'd0 || inst_pc !== 32'd0) begin failures++; $display("FAIL reset_buf got=%h/%h exp=0/0", inst_out, inst_pc); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    rstn = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] addrs[$];
    int          cyc[$];
    int          err_seen;
    err_seen = 0;
    ack = 1'b1; ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fetch_err !== 1'b0) err_seen++;
      if (bus.imem_req === 1'b1) begin
        addrs.push_back(bus.imem_addr);
        cyc.push_back(i);
      end
      if (inst_valid === 1'b1 && addrs.size() > 0) begin
        checks++; if (inst_pc !== addrs[$] || inst_out !== mem_word(addrs[$])) begin
          failures++; $display("FAIL stream_inst got=%h/%h exp=%h/%h", inst_pc, inst_out, addrs[$], mem_word(addrs[$]));
        end
      end
    end
    checks++;
    if (addrs.size() < 3) begin
      failures++; $display("FAIL stream_count got=%0d exp>=3", addrs.size());
    end else begin
      if (addrs[0] !== 32'h3000 || addrs[1] !== 32'h3004 || addrs[2] !== 32'h3008) begin
        failures++; $display("FAIL stream_addrs got=%h,%h,%h exp=3000,3004,3008", addrs[0], addrs[1], addrs[2]);
      end
      checks++; if (cyc[1] - cyc[0] != 2 || cyc[2] - cyc[1] != 2) begin
        failures++; $display("FAIL stream_spacing got=%0d,%0d exp=2,2", cyc[1] - cyc[0], cyc[2] - cyc[1]);
      end
    end
    checks++; if (err_seen != 0) begin failures++; $display("FAIL stream_err got=%0d exp=0", err_seen); end
  endtask

  task automatic test_hold_stall();
    logic [31:0] v_pc, v_out, a0;
    int n;
    ready = 1'b0; ack = 1'b1; n = 0;
    while (inst_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL hold_wait got=timeout exp=valid"); end
    v_pc = inst_pc; v_out = inst_out; a0 = bus.imem_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== v_pc || inst_out !== v_out || bus.imem_req !== 1'b0 || bus.imem_addr !== a0) begin
        failures++; $display("FAIL hold_stable cyc=%0d got v=%b pc=%h out=%h req=%b addr=%h exp v=1 pc=%h out=%h req=0 addr=%h",
                             i, inst_valid, inst_pc, inst_out, bus.imem_req, bus.imem_addr, v_pc, v_out, a0);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== v_pc + 32'd4) begin
      failures++; $display("FAIL hold_release got v=%b req=%b addr=%h exp v=0 req=1 addr=%h", inst_valid, bus.imem_req, bus.imem_addr, v_pc + 32'd4);
    end
  endtask

  task automatic test_branch_flush();
    int n;
    ready = 1'b0; ack = 1'b1; n = 0;
    while (inst_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL branch_wait got=timeout exp=valid"); end
    drive_redir(2'd1, 32'h0000_3010, 26'h000_FFFC, 32'd0);
    ready = 1'b1;
    @(negedge clk);
    redir_valid = 1'b0; ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
      failures++; $display("FAIL branch_flush got v=%b req=%b addr=%h exp v=0 req=1 addr=00003004", inst_valid, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3004 || inst_out !== mem_word(32'h3004)) begin
      failures++; $display("FAIL branch_fetch got v=%b pc=%h out=%h exp v=1 pc=00003004 out=%h", inst_valid, inst_pc, inst_out, mem_word(32'h3004));
    end
  endtask

  task automatic test_drain_jump();
    ack = 1'b0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3008 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL drain_start got req=%b addr=%h v=%b exp req=1 addr=00003008 v=0", bus.imem_req, bus.imem_addr, inst_valid);
    end
    drive_redir(2'd2, 32'h0000_3008, 26'h000_0100, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redir_valid = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3008 || inst_valid !== 1'b0) begin
        failures++; $display("FAIL drain_held cyc=%0d got req=%b addr=%h v=%b exp req=1 addr=00003008 v=0", i, bus.imem_req, bus.imem_addr, inst_valid);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0400) begin
      failures++; $display("FAIL drain_jump got v=%b req=%b addr=%h exp v=0 req=1 addr=00000400", inst_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_two_redirects();
    drive_redir(2'd2, 32'h0000_0400, 26'h000_0200, 32'd0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h400 || fetch_err !== 1'b0) begin
      failures++; $display("FAIL two_first got addr=%h err=%b exp addr=00000400 err=0", bus.imem_addr, fetch_err);
    end
    drive_redir(2'd3, 32'h0000_0400, 26'd0, 32'h0000_5002);
    @(negedge clk);
    redir_valid = 1'b0; ack = 1'b1;
    checks++; if (fetch_err !== 1'b1 || bus.imem_addr !== 32'h400) begin
      failures++; $display("FAIL two_err got err=%b addr=%h exp err=1 addr=00000400", fetch_err, bus.imem_addr);
    end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b0 || inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5000) begin
      failures++; $display("FAIL two_target got err=%b v=%b req=%b addr=%h exp err=0 v=0 req=1 addr=00005000", fetch_err, inst_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    int n;
    ready = 1'b0; ack = 1'b1; n = 0;
    while (inst_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL wrap_wait got=timeout exp=valid"); end
    drive_redir(2'd3, 32'h0000_5000, 26'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || fetch_err !== 1'b0) begin
      failures++; $display("FAIL wrap_top got req=%b addr=%h err=%b exp req=1 addr=fffffffc err=0", bus.imem_req, bus.imem_addr, fetch_err);
    end
    @(negedge clk);
    ready = 1'b1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_inst got v=%b pc=%h exp v=1 pc=fffffffc", inst_valid, inst_pc);
    end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_zero got req=%b addr=%h exp req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] held;
    int n;
    ack = 1'b0; ready = 1'b0; n = 0;
    while (bus.imem_req !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rdrain_wait got=timeout exp=req"); end
    held = bus.imem_addr;
    drive_redir(2'd3, held, 26'd0, 32'h0000_7001);
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (fetch_err !== 1'b1 || bus.imem_addr !== held || bus.imem_req !== 1'b1) begin
      failures++; $display("FAIL rdrain_in got err=%b addr=%h req=%b exp err=1 addr=%h req=1", fetch_err, bus.imem_addr, bus.imem_req, held);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h3000 || inst_valid !== 1'b0 ||
        inst_out !== 32'd0 || inst_pc !== 32'd0 || fetch_err !== 1'b0) begin
      failures++; $display("FAIL rdrain_async got req=%b addr=%h v=%b out=%h pc=%h err=%b exp 0/00003000/0/0/0/0",
                           bus.imem_req, bus.imem_addr, inst_valid, inst_out, inst_pc, fetch_err);
    end
    @(negedge clk);
    rstn = 1'b1; ack = 1'b1; ready = 1'b1; n = 0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin
      failures++; $display("FAIL rdrain_restart got req=%b addr=%h exp req=1 addr=00003000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_next, out_addr, exp_pc;
    logic        outstanding, squashed, exp_valid, exp_err;
    logic        req_o, rd;
    int          bad;
    rstn = 1'b0; ack = 1'b0; ready = 1'b0; redir_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_next = 32'h3000; out_addr = 32'd0; exp_pc = 32'd0;
    outstanding = 1'b0; squashed = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req_o = bus.imem_req;
      checks++; if (req_o !== !exp_valid) begin
        failures++; bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, req_o, !exp_valid);
      end
      if (req_o === 1'b1) begin
        checks++;
        if (!outstanding) begin
          if (bus.imem_addr !== exp_next) begin failures++; bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, exp_next); end
          outstanding = 1'b1; out_addr = bus.imem_addr; squashed = 1'b0;
        end else if (bus.imem_addr !== out_addr) begin
          failures++; bad++; $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, out_addr);
        end
      end
      checks++; if (inst_valid !== exp_valid) begin
        failures++; bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++; if (inst_pc !== exp_pc || inst_out !== mem_word(exp_pc)) begin
          failures++; bad++; $display("FAIL rnd_inst cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_pc, inst_out, exp_pc, mem_word(exp_pc));
        end
      end
      checks++; if (fetch_err !== exp_err) begin
        failures++; bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, fetch_err, exp_err);
      end
      if (bad > 10) break;

      ack   = (req_o === 1'b1) && ($urandom_range(0, 99) < 45);
      ready = ($urandom_range(0, 99) < 60);
      rd    = ((req_o === 1'b1) || exp_valid) && ($urandom_range(0, 99) < 15);
      redir_valid = rd;
      redir_op    = 2'($urandom_range(0, 3));
      redir_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      redir_imm   = 26'($urandom);
      redir_rs    = $urandom;

      exp_err = rd && (redir_op == 2'd3) && (redir_rs[1:0] != 2'b00);
      if (rd) exp_next = ref_target(redir_op, redir_pc, redir_imm, redir_rs);
      if ((req_o === 1'b1) && ack) begin
        outstanding = 1'b0;
        if (!rd && !squashed) begin exp_valid = 1'b1; exp_pc = out_addr; end
      end else if (rd && outstanding) begin
        squashed = 1'b1;
      end else if (exp_valid && (rd || ready)) begin
        exp_valid = 1'b0;
        if (!rd) exp_next = exp_pc + 32'd4;
      end
    end
    @(negedge clk);
    ack = 1'b0; redir_valid = 1'b0; ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold_stall();
    test_branch_flush();
    test_drain_jump();
    test_two_redirects();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
